// File: rtl/main_ram_arbiter.sv
// ============================================================================
// Module      : main_ram_arbiter
// Description : Arbitrates a loader port, a ROM read port and a BSRAM
//               read/write port onto one SDRAM command interface using a
//               req/ack handshake. Only one transaction is in flight at a time.
//               Optional build macro MAIN_RAM_ARB_RR_EN selects round-robin
//               arbitration between ROM and BSRAM (fixed priority otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_ram_arbiter #(
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_done,
  // loader port (write only)
  input  logic        ld_req,
  input  logic [24:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  // ROM port (read only)
  input  logic        rom_req,
  input  logic [23:0] rom_addr,
  input  logic        rom_word,
  output logic        rom_ack,
  output logic [15:0] rom_q,
  // BSRAM port (read/write, byte wide)
  input  logic        bs_req,
  input  logic        bs_we,
  input  logic [19:0] bs_addr,
  input  logic [7:0]  bs_d,
  output logic        bs_ack,
  output logic [7:0]  bs_q,
  // SDRAM controller side
  output logic [24:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic        ram_word,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic        ram_busy
);

  // Counter wide enough to count BUSY_TIMEOUT cycles spent in WAIT_HI.
  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LD   = 2'd1,
    SEL_ROM  = 2'd2,
    SEL_BS   = 2'd3
  } sel_t;

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic              we_q, we_d;
  logic [24:0]       ram_addr_q, ram_addr_d;
  logic              ram_word_q, ram_word_d;
  logic [15:0]       ram_din_q, ram_din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rom_q_q, rom_q_d;
  logic [7:0]        bs_q_q, bs_q_d;

  // Eligibility: load_done splits service between the loader and the
  // ROM/BSRAM pair; it is only consulted while idle.
  logic ld_ok, rom_ok, bs_ok, bs_wins;
  sel_t grant;

  assign ld_ok  = ~load_done & ld_req;
  assign rom_ok = load_done & rom_req;
  assign bs_ok  = load_done & bs_req;

`ifdef MAIN_RAM_ARB_RR_EN
  // rr_rom_first_q=1 means ROM wins the next ROM/BSRAM tie. The pointer
  // only moves when a tie is actually resolved, so the winner of one tie
  // loses the next one.
  logic rr_rom_first_q, rr_rom_first_d;

  assign bs_wins = bs_ok & (~rom_ok | ~rr_rom_first_q);
`else
  assign bs_wins = bs_ok;
`endif

  // Winner selection among eligible requesters.
  always_comb begin
    grant = SEL_NONE;
    if (ld_ok)        grant = SEL_LD;
    else if (bs_wins) grant = SEL_BS;
    else if (rom_ok)  grant = SEL_ROM;
  end

  // Next-state logic and field latching for the command sequencer.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    ram_addr_d = ram_addr_q;
    ram_word_d = ram_word_q;
    ram_din_d  = ram_din_q;
    cnt_d      = cnt_q;
    rom_q_d    = rom_q_q;
    bs_q_d     = bs_q_q;
`ifdef MAIN_RAM_ARB_RR_EN
    rr_rom_first_d = rr_rom_first_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant != SEL_NONE) begin
          sel_d   = grant;
          state_d = ST_ISSUE;
          case (grant)
            SEL_LD: begin
              ram_addr_d = ld_addr;
              ram_word_d = 1'b1;
              ram_din_d  = ld_data;
              we_d       = 1'b1;
            end
            SEL_ROM: begin
              ram_addr_d = {1'b0, rom_addr};
              ram_word_d = rom_word;
              we_d       = 1'b0;
            end
            default: begin
              // BSRAM lives in the upper region of SDRAM; the byte is
              // replicated on both lanes so either lane can be written.
              ram_addr_d = {5'b10000, bs_addr};
              ram_word_d = 1'b0;
              ram_din_d  = {bs_d, bs_d};
              we_d       = bs_we;
            end
          endcase
`ifdef MAIN_RAM_ARB_RR_EN
          if (rom_ok && bs_ok) begin
            rr_rom_first_d = (grant == SEL_BS);
          end
`endif
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end

      // Wait for the controller to acknowledge the command via busy; if it
      // never rises, treat the command as already complete.
      ST_WAIT_HI: begin
        if (ram_busy) begin
          state_d = ST_WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LO: begin
        if (!ram_busy) state_d = ST_ACK;
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        if (!we_q) begin
          if (sel_q == SEL_ROM) rom_q_d = ram_dout;
          if (sel_q == SEL_BS)  bs_q_d  = ram_dout[7:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_NONE;
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_word_q <= 1'b1;
      ram_din_q  <= '0;
      cnt_q      <= '0;
      rom_q_q    <= '0;
      bs_q_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      ram_addr_q <= ram_addr_d;
      ram_word_q <= ram_word_d;
      ram_din_q  <= ram_din_d;
      cnt_q      <= cnt_d;
      rom_q_q    <= rom_q_d;
      bs_q_q     <= bs_q_d;
    end
  end

`ifdef MAIN_RAM_ARB_RR_EN
  // Round-robin pointer; after reset BSRAM wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) rr_rom_first_q <= 1'b0;
    else       rr_rom_first_q <= rr_rom_first_d;
  end
`endif

  // Strobes decode directly from the state register so they are single
  // cycle and forced low by reset on the same edge as the state.
  assign ram_rd   = (state_q == ST_ISSUE) & ~we_q;
  assign ram_wr   = (state_q == ST_ISSUE) &  we_q;
  assign ld_ack   = (state_q == ST_ACK) & (sel_q == SEL_LD);
  assign rom_ack  = (state_q == ST_ACK) & (sel_q == SEL_ROM);
  assign bs_ack   = (state_q == ST_ACK) & (sel_q == SEL_BS);

  assign ram_addr = ram_addr_q;
  assign ram_word = ram_word_q;
  assign ram_din  = ram_din_q;
  assign rom_q    = rom_q_q;
  assign bs_q     = bs_q_q;

endmodule

`default_nettype wire

// File: tb/tb_main_ram_arbiter.sv
// ============================================================================
// Module      : tb_main_ram_arbiter
// Description : Directed self-checking bench for main_ram_arbiter with a
//               small SDRAM busy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_ram_arbiter;

  localparam int BUSY_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_done;
  logic        ld_req;
  logic [24:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_ack;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_word;
  logic        rom_ack;
  logic [15:0] rom_q;
  logic        bs_req;
  logic        bs_we;
  logic [19:0] bs_addr;
  logic [7:0]  bs_d;
  logic        bs_ack;
  logic [7:0]  bs_q;
  logic [24:0] ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic        ram_word;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_busy;

  int n_chk  = 0;
  int n_fail = 0;

  // busy goes high busy_start cycles after the command pulse, for busy_len
  // cycles; busy_start < 0 means busy never rises.
  int busy_start = -1;
  int busy_len   = 0;
  int bcnt       = -1;

  main_ram_arbiter #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_done (load_done),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ack    (ld_ack),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_word  (rom_word),
    .rom_ack   (rom_ack),
    .rom_q     (rom_q),
    .bs_req    (bs_req),
    .bs_we     (bs_we),
    .bs_addr   (bs_addr),
    .bs_d      (bs_d),
    .bs_ack    (bs_ack),
    .bs_q      (bs_q),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_wr    (ram_wr),
    .ram_word  (ram_word),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_busy  (ram_busy)
  );

  always #5 clk = ~clk;

  // SDRAM busy model, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset)                bcnt = -1;
    else if (ram_rd || ram_wr) bcnt = 0;
    else if (bcnt >= 0)       bcnt = bcnt + 1;
    ram_busy = (bcnt >= 0) && (busy_start >= 0) &&
               (bcnt >= busy_start) && (bcnt < busy_start + busy_len);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string nm);
    check($sformatf("%s_rdwr", nm), {ram_rd, ram_wr}, 2'b00);
    check($sformatf("%s_acks", nm), {ld_ack, rom_ack, bs_ack}, 3'b000);
    check($sformatf("%s_addr", nm), ram_addr, 25'h0);
    check($sformatf("%s_din", nm), ram_din, 16'h0);
    check($sformatf("%s_word", nm), ram_word, 1'b1);
    check($sformatf("%s_romq", nm), rom_q, 16'h0);
    check($sformatf("%s_bsq", nm), bs_q, 8'h0);
  endtask

  task automatic wait_issue(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (ram_rd || ram_wr) seen = 1'b1;
    end
  endtask

  // One full transaction: checks the command, the ack, its latency from the
  // ISSUE cycle, and that the ack lasts exactly one cycle.
  task automatic txn(input string nm, input logic [24:0] e_addr, input logic e_wr,
                     input logic [15:0] e_din, input logic e_word,
                     input logic [2:0] e_ack, input int e_lat);
    bit seen;
    int lat;
    wait_issue(seen);
    check($sformatf("%s_issue", nm), seen, 1'b1);
    if (seen) begin
      check($sformatf("%s_rdwr", nm), {ram_rd, ram_wr}, {~e_wr, e_wr});
      check($sformatf("%s_addr", nm), ram_addr, e_addr);
      check($sformatf("%s_word", nm), ram_word, e_word);
      if (e_wr) check($sformatf("%s_din", nm), ram_din, e_din);
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(posedge clk); #1;
        lat++;
        if (ld_ack || rom_ack || bs_ack) seen = 1'b1;
      end
      check($sformatf("%s_ackseen", nm), seen, 1'b1);
      check($sformatf("%s_ack", nm), {ld_ack, rom_ack, bs_ack}, e_ack);
      check($sformatf("%s_lat", nm), lat, e_lat);
      check($sformatf("%s_addr_hold", nm), ram_addr, e_addr);
      if (ld_ack)  ld_req  = 1'b0;
      if (rom_ack) rom_req = 1'b0;
      if (bs_ack)  bs_req  = 1'b0;
      @(posedge clk); #1;
      check($sformatf("%s_ackpulse", nm), {ld_ack, rom_ack, bs_ack}, 3'b000);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; load_done = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    rom_req = 1'b0; rom_addr = '0; rom_word = 1'b0;
    bs_req = 1'b0; bs_we = 1'b0; bs_addr = '0; bs_d = '0;
    ram_dout = '0; ram_busy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    reset = 1'b0;

    // Loader write; a ROM request while load_done=0 must be ignored.
    rom_req = 1'b1; rom_addr = 24'h00ABCD; rom_word = 1'b1;
    ld_addr = 25'h0000123; ld_data = 16'hBEEF; ld_req = 1'b1;
    busy_start = 2; busy_len = 4;
    txn("ld", 25'h0000123, 1'b1, 16'hBEEF, 1'b1, 3'b100, 7);

    // ROM read; a loader request while load_done=1 must be ignored.
    load_done = 1'b1; ld_req = 1'b1;
    ram_dout = 16'h5A5A; busy_start = 1; busy_len = 1;
    txn("rom", 25'h000ABCD, 1'b0, 16'h0, 1'b1, 3'b010, 3);
    ld_req = 1'b0;
    check("rom_q", rom_q, 16'h5A5A);

    // BSRAM write with busy never rising: timeout path.
    bs_req = 1'b1; bs_we = 1'b1; bs_addr = 20'h00010; bs_d = 8'h77;
    busy_start = -1;
    txn("bsw", 25'h1000010, 1'b1, 16'h7777, 1'b0, 3'b001, BUSY_TIMEOUT + 1);

    // BSRAM read at the top of the BSRAM region.
    bs_req = 1'b1; bs_we = 1'b0; bs_addr = 20'hFFFFF;
    ram_dout = 16'h12C3; busy_start = 1; busy_len = 1;
    txn("bsr", 25'h10FFFFF, 1'b0, 16'h0, 1'b0, 3'b001, 3);
    check("bsr_bsq", bs_q, 8'hC3);
    check("bsr_romq_hold", rom_q, 16'h5A5A);

    // Reset during WAIT_LO: no ack, everything back to reset values.
    rom_req = 1'b1; rom_addr = 24'h123456; rom_word = 1'b0;
    busy_start = 2; busy_len = 10;
    wait_issue(seen);
    check("mid_issue", seen, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_noack", {ld_ack, rom_ack, bs_ack}, 3'b000);
    end
    reset = 1'b1; rom_req = 1'b0;
    @(posedge clk); #1;
    reset_checks("mid");
    @(posedge clk); #1;
    reset = 1'b0;

    // Normal service after reset release.
    bs_req = 1'b1; bs_we = 1'b1; bs_addr = 20'h00005; bs_d = 8'hA5;
    busy_start = 1; busy_len = 1;
    txn("post", 25'h1000005, 1'b1, 16'hA5A5, 1'b0, 3'b001, 3);

    // First simultaneous pair: BSRAM first, then ROM.
    bs_req = 1'b1; bs_we = 1'b0; bs_addr = 20'h00020;
    rom_req = 1'b1; rom_addr = 24'h000100; rom_word = 1'b0;
    ram_dout = 16'h0F0F;
    txn("p1a", 25'h1000020, 1'b0, 16'h0, 1'b0, 3'b001, 3);
    txn("p1b", 25'h0000100, 1'b0, 16'h0, 1'b0, 3'b010, 3);
    check("p1_bsq", bs_q, 8'h0F);
    check("p1_romq", rom_q, 16'h0F0F);

    // Second simultaneous pair.
    bs_req = 1'b1; bs_we = 1'b0; bs_addr = 20'h00030;
    rom_req = 1'b1; rom_addr = 24'h000200; rom_word = 1'b1;
    ram_dout = 16'h3C96;
`ifdef MAIN_RAM_ARB_RR_EN
    txn("p2a", 25'h0000200, 1'b0, 16'h0, 1'b1, 3'b010, 3);
    txn("p2b", 25'h1000030, 1'b0, 16'h0, 1'b0, 3'b001, 3);
`else
    txn("p2a", 25'h1000030, 1'b0, 16'h0, 1'b0, 3'b001, 3);
    txn("p2b", 25'h0000200, 1'b0, 16'h0, 1'b1, 3'b010, 3);
`endif
    check("p2_bsq", bs_q, 8'h96);
    check("p2_romq", rom_q, 16'h3C96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
